// File: rtl/ex_operand_if.sv
// Decode/forwarding-to-execute operand bus for the ex_operand_stage pipeline register.
interface ex_operand_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned OP_W  = 4
);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [RA_W-1:0]  rs1_addr;
    logic [RA_W-1:0]  rs2_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic [OP_W-1:0]  alu_op_in;
    logic [RA_W-1:0]  rd_addr_in;
    logic             reg_write_in;
    logic [RA_W-1:0]  exmem_rd;
    logic [RA_W-1:0]  memwb_rd;
    logic             exmem_we;
    logic             memwb_we;
    logic [WIDTH-1:0] exmem_result;
    logic [WIDTH-1:0] memwb_result;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] store_data;
    logic [OP_W-1:0]  alu_op;
    logic [RA_W-1:0]  rd_addr;
    logic             reg_write;
    logic             out_valid;

    modport master (
        output in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
               imm, use_imm, alu_op_in, rd_addr_in, reg_write_in,
               exmem_rd, memwb_rd, exmem_we, memwb_we, exmem_result, memwb_result,
        input  A, B, store_data, alu_op, rd_addr, reg_write, out_valid
    );

    modport slave (
        input  in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
               imm, use_imm, alu_op_in, rd_addr_in, reg_write_in,
               exmem_rd, memwb_rd, exmem_we, memwb_we, exmem_result, memwb_result,
        output A, B, store_data, alu_op, rd_addr, reg_write, out_valid
    );
endinterface

// File: rtl/ex_operand_stage.sv
// Decode->execute pipeline register: resolves forwarding for both ALU operands,
// registers execute control, and handles stall (with late forwarding refresh) and flush.
module ex_operand_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned OP_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_operand_if.slave    bus
);
    logic [WIDTH-1:0] a_q, b_q, sd_q;
    logic [OP_W-1:0]  op_q;
    logic [RA_W-1:0]  rd_q;
    logic             rw_q, v_q;
    logic [RA_W-1:0]  h1_q, h2_q;
    logic             hu_q;

    logic [RA_W-1:0]  em_rd, mw_rd;
    logic             em_we, mw_we;
    logic [WIDTH-1:0] em_res, mw_res;

    logic [WIDTH-1:0] rs1_res_c, rs2_res_c;
    logic [WIDTH-1:0] a_hold_c, b_hold_c, sd_hold_c;

    assign em_rd  = bus.exmem_rd;
    assign mw_rd  = bus.memwb_rd;
    assign em_we  = bus.exmem_we;
    assign mw_we  = bus.memwb_we;
    assign em_res = bus.exmem_result;
    assign mw_res = bus.memwb_result;

    // x0 reads as zero; EX/MEM is the younger producer so it beats MEM/WB.
    function automatic logic [WIDTH-1:0] resolve(
        input logic [RA_W-1:0]  addr,
        input logic [WIDTH-1:0] fallback
    );
        logic [WIDTH-1:0] r;
        r = fallback;
        if (addr == '0)
            r = '0;
        else if (em_we && (em_rd == addr))
            r = em_res;
        else if (mw_we && (mw_rd == addr))
            r = mw_res;
        return r;
    endfunction

    always_comb begin
        rs1_res_c = resolve(bus.rs1_addr, bus.rs1_data);
        rs2_res_c = resolve(bus.rs2_addr, bus.rs2_data);
        // While stalled only a matching producer may overwrite the held operand.
        a_hold_c  = (h1_q == '0) ? a_q : resolve(h1_q, a_q);
        b_hold_c  = (hu_q || (h2_q == '0)) ? b_q : resolve(h2_q, b_q);
        sd_hold_c = (h2_q == '0) ? sd_q : resolve(h2_q, sd_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            sd_q <= '0;
            op_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
            v_q  <= 1'b0;
            h1_q <= '0;
            h2_q <= '0;
            hu_q <= 1'b0;
        end else if (bus.flush) begin
            a_q  <= '0;
            b_q  <= '0;
            sd_q <= '0;
            op_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
            v_q  <= 1'b0;
            h1_q <= '0;
            h2_q <= '0;
            hu_q <= 1'b0;
        end else if (bus.stall) begin
            a_q  <= a_hold_c;
            b_q  <= b_hold_c;
            sd_q <= sd_hold_c;
        end else begin
            a_q  <= rs1_res_c;
            b_q  <= bus.use_imm ? bus.imm : rs2_res_c;
            sd_q <= rs2_res_c;
            op_q <= bus.alu_op_in;
            rd_q <= bus.rd_addr_in;
            rw_q <= bus.in_valid & bus.reg_write_in;
            v_q  <= bus.in_valid;
            h1_q <= bus.rs1_addr;
            h2_q <= bus.rs2_addr;
            hu_q <= bus.use_imm;
        end
    end

    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.store_data = sd_q;
    assign bus.alu_op     = op_q;
    assign bus.rd_addr    = rd_q;
    assign bus.reg_write  = rw_q;
    assign bus.out_valid  = v_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_ex_operand_stage;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OP_W  = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic chk_en   = 1'b0;

    ex_operand_if #(.WIDTH(WIDTH), .RA_W(RA_W), .OP_W(OP_W)) bus ();

    ex_operand_stage #(.WIDTH(WIDTH), .RA_W(RA_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: what the stage must hold, plus the instruction's source addresses.
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_sd = '0;
    logic [OP_W-1:0]  m_op = '0;
    logic [RA_W-1:0]  m_rd = '0, m_s1 = '0, m_s2 = '0;
    logic             m_rw = 1'b0, m_v = 1'b0, m_imm = 1'b0;

    // Newest producer first; register 0 is never produced.
    function automatic logic [WIDTH-1:0] newest_value(input logic [RA_W-1:0] a,
                                                      input logic [WIDTH-1:0] otherwise);
        logic [RA_W-1:0]  prd [2];
        logic             pwe [2];
        logic [WIDTH-1:0] pdat[2];
        prd[0] = bus.exmem_rd;  pwe[0] = bus.exmem_we;  pdat[0] = bus.exmem_result;
        prd[1] = bus.memwb_rd;  pwe[1] = bus.memwb_we;  pdat[1] = bus.memwb_result;
        for (int i = 0; i < 2; i++)
            if (a != 0 && pwe[i] && prd[i] == a) return pdat[i];
        return otherwise;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_sd <= '0; m_op <= '0; m_rd <= '0;
            m_rw <= 1'b0; m_v <= 1'b0; m_s1 <= '0; m_s2 <= '0; m_imm <= 1'b0;
        end else if (bus.flush) begin
            m_a <= '0; m_b <= '0; m_sd <= '0; m_op <= '0; m_rd <= '0;
            m_rw <= 1'b0; m_v <= 1'b0; m_s1 <= '0; m_s2 <= '0; m_imm <= 1'b0;
        end else if (bus.stall) begin
            m_a  <= newest_value(m_s1, m_a);
            m_b  <= m_imm ? m_b : newest_value(m_s2, m_b);
            m_sd <= newest_value(m_s2, m_sd);
        end else begin
            m_a   <= newest_value(bus.rs1_addr, (bus.rs1_addr == 0) ? '0 : bus.rs1_data);
            m_sd  <= newest_value(bus.rs2_addr, (bus.rs2_addr == 0) ? '0 : bus.rs2_data);
            m_b   <= bus.use_imm ? bus.imm
                                 : newest_value(bus.rs2_addr, (bus.rs2_addr == 0) ? '0 : bus.rs2_data);
            m_op  <= bus.alu_op_in;
            m_rd  <= bus.rd_addr_in;
            m_rw  <= bus.in_valid && bus.reg_write_in;
            m_v   <= bus.in_valid;
            m_s1  <= bus.rs1_addr;
            m_s2  <= bus.rs2_addr;
            m_imm <= bus.use_imm;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_A",         bus.A,                   m_a);
            check("model_B",         bus.B,                   m_b);
            check("model_store",     bus.store_data,          m_sd);
            check("model_alu_op",    64'(bus.alu_op),         64'(m_op));
            check("model_rd_addr",   64'(bus.rd_addr),        64'(m_rd));
            check("model_reg_write", 64'(bus.reg_write),      64'(m_rw));
            check("model_out_valid", 64'(bus.out_valid),      64'(m_v));
        end
    end

    task automatic idle();
        bus.in_valid = 0; bus.stall = 0; bus.flush = 0;
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rs1_data = 0; bus.rs2_data = 0;
        bus.imm = 0; bus.use_imm = 0; bus.alu_op_in = 0; bus.rd_addr_in = 0;
        bus.reg_write_in = 0; bus.exmem_rd = 0; bus.memwb_rd = 0;
        bus.exmem_we = 0; bus.memwb_we = 0; bus.exmem_result = 0; bus.memwb_result = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        step();
        check("reset_A",     bus.A, 64'h0);
        check("reset_valid", 64'(bus.out_valid), 64'h0);
        rst_n = 1'b1;

        // Forwarding priority on rs1
        bus.in_valid = 1; bus.reg_write_in = 1; bus.alu_op_in = 4'd5; bus.rd_addr_in = 5'd7;
        bus.rs1_addr = 5'd3; bus.rs1_data = 64'h1234;
        bus.exmem_rd = 5'd3; bus.exmem_we = 1; bus.exmem_result = 64'hAAAA;
        bus.memwb_rd = 5'd3; bus.memwb_we = 1; bus.memwb_result = 64'hBBBB;
        step();
        check("fwd_exmem_wins", bus.A, 64'hAAAA);
        check("load_valid",     64'(bus.out_valid), 64'h1);
        check("load_reg_write", 64'(bus.reg_write), 64'h1);
        check("load_alu_op",    64'(bus.alu_op), 64'h5);
        check("load_rd",        64'(bus.rd_addr), 64'h7);
        bus.exmem_we = 0;
        step();
        check("fwd_memwb", bus.A, 64'hBBBB);
        bus.memwb_we = 0;
        step();
        check("fwd_none", bus.A, 64'h1234);

        // x0 guard
        bus.rs2_addr = 5'd0; bus.rs2_data = 64'h55; bus.use_imm = 0;
        bus.exmem_rd = 5'd0; bus.exmem_we = 1; bus.exmem_result = 64'hFFFF;
        step();
        check("x0_B",     bus.B, 64'h0);
        check("x0_store", bus.store_data, 64'h0);

        // Immediate B with forwarded store data
        bus.use_imm = 1; bus.imm = 64'hFFFF_FFFF_FFFF_FFF0;
        bus.rs2_addr = 5'd6; bus.rs2_data = 64'h99;
        bus.exmem_rd = 5'd6; bus.exmem_we = 1; bus.exmem_result = 64'h11;
        step();
        check("imm_B",     bus.B, 64'hFFFF_FFFF_FFFF_FFF0);
        check("imm_store", bus.store_data, 64'h11);

        // Late forward during stall
        idle();
        bus.in_valid = 1; bus.reg_write_in = 1; bus.alu_op_in = 4'd9; bus.rd_addr_in = 5'd10;
        bus.rs1_addr = 5'd4; bus.rs1_data = 64'h1;
        step();
        check("stall_pre_A", bus.A, 64'h1);
        bus.stall = 1; bus.in_valid = 0; bus.alu_op_in = 4'd3; bus.rs1_data = 64'hDEAD;
        step();
        check("stall1_A",  bus.A, 64'h1);
        check("stall1_op", 64'(bus.alu_op), 64'h9);
        bus.exmem_rd = 5'd4; bus.exmem_we = 1; bus.exmem_result = 64'h42;
        step();
        check("stall2_A",     bus.A, 64'h42);
        check("stall2_op",    64'(bus.alu_op), 64'h9);
        check("stall2_rd",    64'(bus.rd_addr), 64'd10);
        check("stall2_valid", 64'(bus.out_valid), 64'h1);

        // Flush beats stall, then a normal load
        bus.flush = 1;
        step();
        check("flush_valid", 64'(bus.out_valid), 64'h0);
        check("flush_rw",    64'(bus.reg_write), 64'h0);
        check("flush_A",     bus.A, 64'h0);
        check("flush_B",     bus.B, 64'h0);
        idle();
        bus.in_valid = 1; bus.rs1_addr = 5'd2; bus.rs1_data = 64'h77;
        step();
        check("post_flush_A",     bus.A, 64'h77);
        check("post_flush_valid", 64'(bus.out_valid), 64'h1);

        // Asynchronous reset between edges
        bus.rs1_addr = 5'd1; bus.rs1_data = 64'd5; bus.rs2_addr = 5'd2; bus.rs2_data = 64'd7;
        step();
        check("pre_rst_A", bus.A, 64'd5);
        check("pre_rst_B", bus.B, 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_A",     bus.A, 64'h0);
        check("async_rst_B",     bus.B, 64'h0);
        check("async_rst_valid", 64'(bus.out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, small address space to provoke forwarding hits
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            bus.rs1_addr     = 5'($urandom_range(0, 7));
            bus.rs2_addr     = 5'($urandom_range(0, 7));
            bus.rs1_data     = {$urandom, $urandom};
            bus.rs2_data     = {$urandom, $urandom};
            bus.imm          = {$urandom, $urandom};
            bus.use_imm      = 1'($urandom_range(0, 1));
            bus.alu_op_in    = 4'($urandom);
            bus.rd_addr_in   = 5'($urandom);
            bus.reg_write_in = 1'($urandom_range(0, 1));
            bus.exmem_rd     = 5'($urandom_range(0, 7));
            bus.memwb_rd     = 5'($urandom_range(0, 7));
            bus.exmem_we     = 1'($urandom_range(0, 1));
            bus.memwb_we     = 1'($urandom_range(0, 1));
            bus.exmem_result = {$urandom, $urandom};
            bus.memwb_result = {$urandom, $urandom};
            if (c == 1000) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
